axi4_slave_mem: RTL and testbench

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

---
 rtl/axi4_slave_mem_if.sv | 62 ++++++
 rtl/axi4_slave_mem.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between an AXI master and the axi4_slave_mem memory slave.
// Signal names follow the AXI4 slave-side naming so waveforms read naturally.
interface axi4_slave_mem_if;
    // Write address channel
    logic [3:0]  S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    // Write data channel
    logic [63:0] S_AXI_WDATA;
    logic [7:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    // Write response channel
    logic [3:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    // Read address channel
    logic [3:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    // Read data channel
    logic [3:0]  S_AXI_RID;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 burst-capable 64-bit memory slave with independent read and write engines.
// Supports FIXED/INCR/WRAP bursts, byte strobes and SLVERR on out-of-range beats.
module axi4_slave_mem #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst,
    axi4_slave_mem_if.slave s_axi
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic       {R_IDLE, R_DATA}         rState_t;

    logic [63:0] r_mem [DEPTH];

    // True when the byte address lies inside the memory window
    function automatic logic inRange(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 3)) == 32'd0);
    endfunction

    // Word index of a byte address; the low three address bits are ignored
    function automatic logic [DEPTH_LOG2-1:0] wordIdx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[DEPTH_LOG2+2:3];
    endfunction

    // Reserved burst code or a WRAP whose length is not 2/4/8/16 beats
    function automatic logic burstBad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                      (len == 8'd7) || (len == 8'd15)));
    endfunction

    // Illegal bursts are carried out as INCR so the transfer still completes
    function automatic logic [1:0] effBurst(input logic [1:0] burst, input logic [7:0] len);
        return burstBad(burst, len) ? 2'b01 : burst;
    endfunction

    // Address of the following beat; WRAP stays inside a (len+1)*8-byte aligned window
    function automatic logic [31:0] nextAddr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst);
        logic [31:0] mask;
        mask = {21'd0, len, 3'b111};
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + 32'd8) & mask);
            default: return addr + 32'd8;
        endcase
    endfunction

    // ---------------- write engine ----------------
    wState_t     r_wState;
    wState_t     w_wStateNext;
    logic [3:0]  r_wId;
    logic [31:0] r_wAddr;
    logic [7:0]  r_wLen;
    logic [1:0]  r_wBurst;
    logic [7:0]  r_wCnt;
    logic        r_wErr;
    logic        w_awReady;
    logic        w_wReady;
    logic        w_bValid;
    logic        w_awFire;
    logic        w_wFire;
    logic        w_bFire;
    logic        w_wBeatLast;
    logic        w_wInRange;
    logic [DEPTH_LOG2-1:0] w_wIdx;

    assign w_awFire    = w_awReady && s_axi.S_AXI_AWVALID;
    assign w_wFire     = w_wReady && s_axi.S_AXI_WVALID;
    assign w_bFire     = w_bValid && s_axi.S_AXI_BREADY;
    assign w_wBeatLast = (r_wCnt == r_wLen);
    assign w_wInRange  = inRange(r_wAddr);
    assign w_wIdx      = wordIdx(r_wAddr);

    // Write FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wState <= W_IDLE;
        else     r_wState <= w_wStateNext;
    end

    // Write FSM transitions: address, data beats until LEN, then response
    always_comb begin
        w_wStateNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_awFire) w_wStateNext = W_DATA;
            W_DATA:  if (w_wFire && w_wBeatLast) w_wStateNext = W_RESP;
            W_RESP:  if (w_bFire) w_wStateNext = W_IDLE;
            default: w_wStateNext = W_IDLE;
        endcase
    end

    // Write channel handshake outputs; AWREADY is held low while in reset
    always_comb begin
        w_awReady = 1'b0;
        w_wReady  = 1'b0;
        w_bValid  = 1'b0;
        case (r_wState)
            W_IDLE:  w_awReady = !rst;
            W_DATA:  w_wReady  = 1'b1;
            W_RESP:  w_bValid  = 1'b1;
            default: ;
        endcase
    end

    // Burst context: latched on AW, stepped per W beat, error flag accumulates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wId    <= 4'd0;
            r_wAddr  <= 32'd0;
            r_wLen   <= 8'd0;
            r_wBurst <= 2'd0;
            r_wCnt   <= 8'd0;
            r_wErr   <= 1'b0;
        end else if (w_awFire) begin
            r_wId    <= s_axi.S_AXI_AWID;
            r_wAddr  <= s_axi.S_AXI_AWADDR;
            r_wLen   <= s_axi.S_AXI_AWLEN;
            r_wBurst <= effBurst(s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLEN);
            r_wCnt   <= 8'd0;
            r_wErr   <= burstBad(s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLEN);
        end else if (w_wFire) begin
            r_wAddr <= nextAddr(r_wAddr, r_wLen, r_wBurst);
            r_wCnt  <= r_wCnt + 8'd1;
            if (!w_wInRange || (s_axi.S_AXI_WLAST != w_wBeatLast))
                r_wErr <= 1'b1;
        end
    end

    // Storage update: only strobed bytes of in-range beats; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wFire && w_wInRange) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.S_AXI_WSTRB[b])
                    r_mem[w_wIdx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awReady;
    assign s_axi.S_AXI_WREADY  = w_wReady;
    assign s_axi.S_AXI_BVALID  = w_bValid;
    assign s_axi.S_AXI_BID     = r_wId;
    assign s_axi.S_AXI_BRESP   = r_wErr ? 2'b10 : 2'b00;

    // ---------------- read engine ----------------
    rState_t     r_rState;
    rState_t     w_rStateNext;
    logic [3:0]  r_rId;
    logic [31:0] r_rAddr;
    logic [7:0]  r_rLen;
    logic [1:0]  r_rBurst;
    logic [7:0]  r_rCnt;
    logic [63:0] r_rData;
    logic [1:0]  r_rResp;
    logic        w_arReady;
    logic        w_rValid;
    logic        w_arFire;
    logic        w_rFire;
    logic        w_rBeatLast;
    logic        w_rLaunch;
    logic [31:0] w_rLaunchAddr;
    logic [DEPTH_LOG2-1:0] w_rIdx;

    assign w_arFire      = w_arReady && s_axi.S_AXI_ARVALID;
    assign w_rFire       = w_rValid && s_axi.S_AXI_RREADY;
    assign w_rBeatLast   = (r_rCnt == r_rLen);
    assign w_rLaunch     = w_arFire || (w_rFire && !w_rBeatLast);
    assign w_rLaunchAddr = (r_rState == R_IDLE) ? s_axi.S_AXI_ARADDR
                                                : nextAddr(r_rAddr, r_rLen, r_rBurst);
    assign w_rIdx        = wordIdx(w_rLaunchAddr);

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rState <= R_IDLE;
        else     r_rState <= w_rStateNext;
    end

    // Read FSM transitions: stay in R_DATA until the last beat is accepted
    always_comb begin
        w_rStateNext = r_rState;
        case (r_rState)
            R_IDLE:  if (w_arFire) w_rStateNext = R_DATA;
            R_DATA:  if (w_rFire && w_rBeatLast) w_rStateNext = R_IDLE;
            default: w_rStateNext = R_IDLE;
        endcase
    end

    // Read channel handshake outputs; ARREADY is held low while in reset
    always_comb begin
        w_arReady = 1'b0;
        w_rValid  = 1'b0;
        case (r_rState)
            R_IDLE:  w_arReady = !rst;
            R_DATA:  w_rValid  = 1'b1;
            default: ;
        endcase
    end

    // Beat launch: data is captured before any same-cycle write lands, so old data is returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rId    <= 4'd0;
            r_rAddr  <= 32'd0;
            r_rLen   <= 8'd0;
            r_rBurst <= 2'd0;
            r_rCnt   <= 8'd0;
            r_rData  <= 64'd0;
            r_rResp  <= 2'b00;
        end else begin
            if (w_arFire) begin
                r_rId    <= s_axi.S_AXI_ARID;
                r_rLen   <= s_axi.S_AXI_ARLEN;
                r_rBurst <= effBurst(s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLEN);
                r_rCnt   <= 8'd0;
            end else if (w_rFire && !w_rBeatLast) begin
                r_rCnt <= r_rCnt + 8'd1;
            end
            if (w_rLaunch) begin
                r_rAddr <= w_rLaunchAddr;
                if (inRange(w_rLaunchAddr)) begin
                    r_rData <= r_mem[w_rIdx];
                    r_rResp <= 2'b00;
                end else begin
                    r_rData <= 64'd0;
                    r_rResp <= 2'b10;
                end
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = w_arReady;
    assign s_axi.S_AXI_RVALID  = w_rValid;
    assign s_axi.S_AXI_RLAST   = w_rValid && w_rBeatLast;
    assign s_axi.S_AXI_RID     = r_rId;
    assign s_axi.S_AXI_RDATA   = r_rData;
    assign s_axi.S_AXI_RRESP   = r_rResp;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed testbench for axi4_slave_mem: bursts, strobes, range errors, stalls, reset.
module tb_axi4_slave_mem;
    logic clk;
    logic rst;

    axi4_slave_mem_if axi();

    axi4_slave_mem #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH_LOG2(10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_axi(axi)
    );

    int totalCnt = 0;
    int badCnt   = 0;

    logic [63:0] wBeat [16];
    logic [63:0] rData [16];
    logic [1:0]  rResp [16];
    logic        rLast [16];
    logic [3:0]  rIdSeen;
    logic [3:0]  bidSeen;
    logic [1:0]  brespSeen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input int stopAfter);
        int t;
        axi.S_AXI_AWID    = id;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWLEN   = len;
        axi.S_AXI_AWBURST = burst;
        axi.S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!axi.S_AXI_AWREADY && t < 50) begin @(posedge clk); #1; t++; end
        checkOutput("awready", 64'(axi.S_AXI_AWREADY), 64'd1);
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.S_AXI_WDATA  = wBeat[i];
            axi.S_AXI_WSTRB  = strb;
            axi.S_AXI_WLAST  = (i == int'(len));
            axi.S_AXI_WVALID = 1'b1;
            t = 0;
            while (!axi.S_AXI_WREADY && t < 50) begin @(posedge clk); #1; t++; end
            checkOutput("wready", 64'(axi.S_AXI_WREADY), 64'd1);
            @(posedge clk); #1;
            if (stopAfter == i + 1) begin
                axi.S_AXI_WVALID = 1'b0;
                axi.S_AXI_WLAST  = 1'b0;
                return;
            end
        end
        axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_WLAST  = 1'b0;
        checkOutput("bvalid_next_cycle", 64'(axi.S_AXI_BVALID), 64'd1);
        bidSeen   = axi.S_AXI_BID;
        brespSeen = axi.S_AXI_BRESP;
        axi.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_BREADY = 1'b0;
        checkOutput("bvalid_clear", 64'(axi.S_AXI_BVALID), 64'd0);
    endtask

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
        int t;
        axi.S_AXI_ARID    = id;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARLEN   = len;
        axi.S_AXI_ARBURST = burst;
        axi.S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!axi.S_AXI_ARREADY && t < 50) begin @(posedge clk); #1; t++; end
        checkOutput("arready", 64'(axi.S_AXI_ARREADY), 64'd1);
        @(posedge clk); #1;
        axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        int t;
        axi.S_AXI_RREADY = 1'b1;
        sendAr(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!axi.S_AXI_RVALID && t < 50) begin @(posedge clk); #1; t++; end
            checkOutput("rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
            rData[i] = axi.S_AXI_RDATA;
            rResp[i] = axi.S_AXI_RRESP;
            rLast[i] = axi.S_AXI_RLAST;
            rIdSeen  = axi.S_AXI_RID;
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus();
        // Single INCR burst write and readback
        for (int i = 0; i < 4; i++) wBeat[i] = 64'(i + 1);
        writeBurst(4'h5, 32'h8000_0000, 8'd3, 2'b01, 8'hFF, 0);
        checkOutput("incr_bid", 64'(bidSeen), 64'h5);
        checkOutput("incr_bresp", 64'(brespSeen), 64'h0);
        readBurst(4'h9, 32'h8000_0000, 8'd3, 2'b01);
        checkOutput("incr_rid", 64'(rIdSeen), 64'h9);
        for (int i = 0; i < 4; i++) begin
            checkOutput("incr_rdata", rData[i], 64'(i + 1));
            checkOutput("incr_rresp", 64'(rResp[i]), 64'd0);
            checkOutput("incr_rlast", 64'(rLast[i]), (i == 3) ? 64'd1 : 64'd0);
        end
        checkOutput("arready_after_last", 64'(axi.S_AXI_ARREADY), 64'd1);

        // WRAP read from 0x18: words 3,0,1,2
        readBurst(4'h2, 32'h8000_0018, 8'd3, 2'b10);
        checkOutput("wrap_b0", rData[0], 64'd4);
        checkOutput("wrap_b1", rData[1], 64'd1);
        checkOutput("wrap_b2", rData[2], 64'd2);
        checkOutput("wrap_b3", rData[3], 64'd3);
        checkOutput("wrap_rlast", 64'(rLast[3]), 64'd1);

        // Byte strobes: only low four bytes overwritten
        wBeat[0] = 64'h0;
        writeBurst(4'h1, 32'h8000_0100, 8'd0, 2'b01, 8'hFF, 0);
        wBeat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        writeBurst(4'h1, 32'h8000_0100, 8'd0, 2'b01, 8'h0F, 0);
        checkOutput("strb_bresp", 64'(brespSeen), 64'h0);
        readBurst(4'h2, 32'h8000_0100, 8'd0, 2'b01);
        checkOutput("strb_rdata", rData[0], 64'h0000_0000_FFFF_FFFF);
        checkOutput("single_rlast", 64'(rLast[0]), 64'd1);

        // Out-of-range write is dropped (its index would alias word 0) and errors
        wBeat[0] = 64'hDEAD_BEEF_0000_0000;
        writeBurst(4'h6, 32'h8000_2000, 8'd0, 2'b01, 8'hFF, 0);
        checkOutput("oor_bid", 64'(bidSeen), 64'h6);
        checkOutput("oor_bresp", 64'(brespSeen), 64'h2);
        readBurst(4'h7, 32'h8000_0000, 8'd0, 2'b01);
        checkOutput("oor_mem_kept", rData[0], 64'd1);
        readBurst(4'h7, 32'h8000_2000, 8'd0, 2'b01);
        checkOutput("oor_rdata", rData[0], 64'd0);
        checkOutput("oor_rresp", 64'(rResp[0]), 64'h2);
        readBurst(4'h7, 32'h7FFF_FFF8, 8'd0, 2'b01);
        checkOutput("below_base_rresp", 64'(rResp[0]), 64'h2);
        readBurst(4'h7, 32'h8000_1FF8, 8'd0, 2'b01);
        checkOutput("top_word_rresp", 64'(rResp[0]), 64'h0);

        // FIXED burst: both beats land on the same word
        wBeat[0] = 64'hA;
        wBeat[1] = 64'hB;
        writeBurst(4'h4, 32'h8000_0040, 8'd1, 2'b00, 8'hFF, 0);
        checkOutput("fixed_bresp", 64'(brespSeen), 64'h0);
        readBurst(4'h4, 32'h8000_0040, 8'd1, 2'b01);
        checkOutput("fixed_word", rData[0], 64'hB);
        checkOutput("fixed_next_untouched", rData[1] == 64'hA ? 64'd1 : 64'd0, 64'd0);

        // WRAP with LEN=2 is illegal: performed as INCR and flagged
        wBeat[0] = 64'd7;
        wBeat[1] = 64'd8;
        wBeat[2] = 64'd9;
        writeBurst(4'h8, 32'h8000_0080, 8'd2, 2'b10, 8'hFF, 0);
        checkOutput("badwrap_bresp", 64'(brespSeen), 64'h2);
        readBurst(4'h8, 32'h8000_0080, 8'd2, 2'b01);
        checkOutput("badwrap_b0", rData[0], 64'd7);
        checkOutput("badwrap_b1", rData[1], 64'd8);
        checkOutput("badwrap_b2", rData[2], 64'd9);

        // RREADY stalled five cycles: RDATA/RLAST must hold
        axi.S_AXI_RREADY = 1'b0;
        sendAr(4'hA, 32'h8000_0000, 8'd1, 2'b01);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
            checkOutput("stall_rdata", axi.S_AXI_RDATA, 64'd1);
            checkOutput("stall_rlast", 64'(axi.S_AXI_RLAST), 64'd0);
            @(posedge clk); #1;
        end
        axi.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_b1_rdata", axi.S_AXI_RDATA, 64'd2);
        checkOutput("stall_b1_rlast", 64'(axi.S_AXI_RLAST), 64'd1);
        @(posedge clk); #1;
        checkOutput("stall_done_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
        checkOutput("stall_done_arready", 64'(axi.S_AXI_ARREADY), 64'd1);

        // Reset after two beats of an eight-beat write aborts it
        for (int i = 0; i < 8; i++) wBeat[i] = 64'h100 + 64'(i);
        writeBurst(4'h3, 32'h8000_0200, 8'd7, 2'b01, 8'hFF, 2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wready", 64'(axi.S_AXI_WREADY), 64'd0);
        checkOutput("midrst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        checkOutput("midrst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_awready_release", 64'(axi.S_AXI_AWREADY), 64'd1);
        checkOutput("midrst_arready_release", 64'(axi.S_AXI_ARREADY), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("midrst_no_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        end
        readBurst(4'hB, 32'h8000_0200, 8'd1, 2'b01);
        checkOutput("midrst_beat0_kept", rData[0], 64'h100);
        checkOutput("midrst_beat1_kept", rData[1], 64'h101);
        readBurst(4'hB, 32'h8000_0008, 8'd0, 2'b01);
        checkOutput("mem_not_reset", rData[0], 64'd2);
    endtask

    initial begin
        rst = 1'b1;
        axi.S_AXI_AWID = '0; axi.S_AXI_AWADDR = '0; axi.S_AXI_AWLEN = '0;
        axi.S_AXI_AWBURST = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WLAST = 1'b0;
        axi.S_AXI_WVALID = 1'b0; axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARID = '0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARLEN = '0;
        axi.S_AXI_ARBURST = '0; axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        checkOutput("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
        checkOutput("rst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        checkOutput("rst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
        checkOutput("rst_rdata", axi.S_AXI_RDATA, 64'd0);
        checkOutput("rst_wready", 64'(axi.S_AXI_WREADY), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("release_awready", 64'(axi.S_AXI_AWREADY), 64'd1);
        checkOutput("release_arready", 64'(axi.S_AXI_ARREADY), 64'd1);
        applyStimulus();
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
